// File: rtl/apb_master.sv
// APB requester: one valid/ready command in, SETUP->ACCESS transfer out, one response pulse back.
// Optional ACCESS wait-state abort is enabled by defining APB_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_Pclk,
  input  logic                  i_Presetn,
  input  logic                  i_Cmd_valid,
  output logic                  o_Cmd_ready,
  input  logic                  i_Cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_Cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_Cmd_wdata,
  output logic                  o_Rsp_valid,
  output logic [DATA_WIDTH-1:0] o_Rsp_rdata,
  output logic                  o_Rsp_error,
  output logic [ADDR_WIDTH-1:0] o_Paddr,
  output logic                  o_Psel,
  output logic                  o_Penable,
  output logic                  o_Pwrite,
  output logic [DATA_WIDTH-1:0] o_Pwdata,
  input  logic [DATA_WIDTH-1:0] i_Prdata,
  input  logic                  i_Pready,
  input  logic                  i_Pslverr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_Cmd_valid) begin
          paddr_d  = i_Cmd_addr;
          pwdata_d = i_Cmd_wdata;
          pwrite_d = i_Cmd_write;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
`ifdef APB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (i_Pready) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = i_Pslverr;
          rsp_rdata_d = pwrite_q ? '0 : i_Prdata;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        // A ready slave on the limit cycle still completes normally (branch above).
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Pclk or negedge i_Presetn) begin
    if (!i_Presetn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign o_Cmd_ready = (state_q == ST_IDLE);
  assign o_Paddr     = paddr_q;
  assign o_Pwdata    = pwdata_q;
  assign o_Pwrite    = pwrite_q;
  assign o_Psel      = psel_q;
  assign o_Penable   = penable_q;
  assign o_Rsp_valid = rsp_valid_q;
  assign o_Rsp_rdata = rsp_rdata_q;
  assign o_Rsp_error = rsp_error_q;

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that drives the peripheral bus toward the USRT register slave. Accepts single read/write commands from the local controller over a valid/ready handshake, runs the APB SETUP→ACCESS sequence, honours wait states and slave error, and returns one response pulse per command. Sits between the system-side command source and the USRT's APB bus interface.

## Interface
- ADDR_WIDTH, 8, width of command address and o_Paddr
- DATA_WIDTH, 8, width of write/read data
- TIMEOUT_CYCLES, 16, max ACCESS cycles with i_Pready low before abort (used only with APB_TIMEOUT_EN)

- i_Pclk  in  1  bus clock; all logic on rising edge
- i_Presetn  in  1  asynchronous active-low reset
- i_Cmd_valid  in  1  command present
- o_Cmd_ready  out  1  block can accept a command
- i_Cmd_write  in  1  1 = write, 0 = read
- i_Cmd_addr  in  ADDR_WIDTH  target address
- i_Cmd_wdata  in  DATA_WIDTH  write data
- o_Rsp_valid  out  1  one-cycle response pulse
- o_Rsp_rdata  out  DATA_WIDTH  read data (0 for writes and aborts)
- o_Rsp_error  out  1  i_Pslverr at completion, or timeout abort
- o_Paddr  out  ADDR_WIDTH  APB address
- o_Psel  out  1  APB select
- o_Penable  out  1  APB enable
- o_Pwrite  out  1  APB direction
- o_Pwdata  out  DATA_WIDTH  APB write data
- i_Prdata  in  DATA_WIDTH  APB read data
- i_Pready  in  1  APB ready (tie high for zero-wait slaves)
- i_Pslverr  in  1  APB slave error

## Operation
- States: IDLE, SETUP, ACCESS. Reset → IDLE.
- o_Cmd_ready = 1 only in IDLE (decoded from state register).
- IDLE: on i_Cmd_valid && o_Cmd_ready, register addr/write/wdata onto o_Paddr/o_Pwrite/o_Pwdata, set o_Psel=1, → SETUP. Otherwise stay.
- SETUP: set o_Penable=1, → ACCESS. Unconditional, exactly one cycle.
- ACCESS: hold all APB outputs stable. When i_Pready=1: capture i_Prdata (reads) into o_Rsp_rdata, o_Rsp_error=i_Pslverr, pulse o_Rsp_valid, clear o_Psel/o_Penable, → IDLE. When i_Pready=0: stay (wait state).
- Write response: o_Rsp_rdata=0, o_Rsp_error=i_Pslverr.
- o_Paddr/o_Pwrite/o_Pwdata retain last values after a transfer; they change only on command acceptance.
- i_Cmd_* ignored outside IDLE; i_Prdata/i_Pready/i_Pslverr ignored outside ACCESS.
- o_Rsp_rdata/o_Rsp_error hold until next response; valid only with o_Rsp_valid.
- Reset asserted any time, including mid-transfer: all outputs → 0 immediately, state IDLE, no response emitted for the aborted command.

## Timing
- Reset values: o_Psel, o_Penable, o_Pwrite, o_Paddr, o_Pwdata, o_Rsp_valid, o_Rsp_rdata, o_Rsp_error = 0; o_Cmd_ready = 1 after reset release.
- Command accepted at edge N → SETUP (o_Psel=1, o_Penable=0) during cycle N+1 → ACCESS (o_Psel=1, o_Penable=1) from N+2.
- Zero-wait slave: i_Pready sampled high at edge N+3 → o_Rsp_valid=1 and o_Psel=o_Penable=0 during N+3; o_Cmd_ready=1 same cycle.
- Each wait cycle (i_Pready=0) adds one cycle.
- Minimum 3 cycles per transfer; next command can be accepted in the cycle o_Rsp_valid is high, giving o_Psel low for exactly one cycle between back-to-back transfers.

## Configuration
- APB_TIMEOUT_EN defined: counter cleared on SETUP entry, increments each ACCESS cycle with i_Pready=0; on ACCESS cycle where counter == TIMEOUT_CYCLES and i_Pready=0, end transfer: o_Rsp_valid=1, o_Rsp_error=1, o_Rsp_rdata=0, o_Psel/o_Penable→0, → IDLE. i_Pready=1 on that same cycle wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely for i_Pready; TIMEOUT_CYCLES unused.

## Test plan
- Write addr 0x01 data 0xA5, i_Pready=1 → o_Psel high 2 cycles, o_Penable high 1 cycle, o_Pwrite=1, o_Pwdata=0xA5; o_Rsp_valid 3 cycles after accept, error=0, rdata=0.
- Read addr 0x02, i_Prdata=0x3C, i_Pready low 2 ACCESS cycles → APB outputs stable, o_Rsp_valid 5 cycles after accept, rdata=0x3C.
- Read with i_Pslverr=1 at completion → o_Rsp_error=1, rdata captured, single response pulse.
- i_Cmd_valid held high for 3 commands → o_Psel low exactly one cycle between transfers, 3 responses in order.
- Reset asserted during ACCESS → all outputs 0 immediately, no o_Rsp_valid; new command after release runs normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, i_Pready stuck low → abort response with error=1, rdata=0, o_Psel dropped; without macro, o_Psel stays high for 100 cycles.
